// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm game controller and the note spectrum
// generator: game state codes and the beat counter width.
package rhythm_pkg;

  localparam int BEAT_W = 10;

  localparam logic [3:0] SEL_SONG1 = 4'd0;
  localparam logic [3:0] SEL_SONG2 = 4'd1;
  localparam logic [3:0] PLAY1     = 4'd2;
  localparam logic [3:0] PLAY2     = 4'd3;
  localparam logic [3:0] ENDING    = 4'd4;
  localparam logic [3:0] PLAY1_PS  = 4'd5;
  localparam logic [3:0] PLAY1_PM  = 4'd6;
  localparam logic [3:0] PLAY2_PS  = 4'd7;
  localparam logic [3:0] PLAY2_PM  = 4'd8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping. A clear takes
// priority over an increment in the same cycle.
module sat_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, hold once the maximum value is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/rhythm_ctrl.sv
// Game flow controller for the rhythm game: song selection, play, pause
// menu and ending screen. Counts beats and player hits per song and emits
// a one-cycle step pulse to the note spectrum generator per played beat.
//
// state     | meaning
// ----------+---------------------------------------------------
// SEL_SONG1 | menu, song 1 highlighted
// SEL_SONG2 | menu, song 2 highlighted
// PLAY1     | song 1 running
// PLAY2     | song 2 running
// ENDING    | song finished, counters frozen for display
// PLAY1_PS  | song 1 paused, "resume" highlighted
// PLAY1_PM  | song 1 paused, "return to menu" highlighted
// PLAY2_PS  | song 2 paused, "resume" highlighted
// PLAY2_PM  | song 2 paused, "return to menu" highlighted
module rhythm_ctrl
  import rhythm_pkg::*;
#(
  parameter int SONG1_LEN = 128,
  parameter int SONG2_LEN = 160,
  parameter int SCORE_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_center,
  input  logic               beat_tick,
  input  logic               note_hit,
  output logic [3:0]         mode,
  output logic               start_sign,
  output logic [BEAT_W-1:0]  beat_cnt,
  output logic [SCORE_W-1:0] score
);

  localparam logic [BEAT_W-1:0] LAST1 = BEAT_W'(SONG1_LEN - 1);
  localparam logic [BEAT_W-1:0] LAST2 = BEAT_W'(SONG2_LEN - 1);

  logic [3:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_d;
  logic              start_d;
  logic              score_clr, score_inc;
  logic              nav;

  // Left and right pressed together are a single navigation event.
  assign nav = btn_left | btn_right;

  // Next-state and counter control; center always beats navigation and ticks.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_cnt;
    start_d   = 1'b0;
    score_clr = 1'b0;
    score_inc = 1'b0;
    case (state_q)
      SEL_SONG1: begin
        if (btn_center) begin
          state_d   = PLAY1;
          beat_d    = '0;
          score_clr = 1'b1;
        end else if (nav) begin
          state_d = SEL_SONG2;
        end
      end
      SEL_SONG2: begin
        if (btn_center) begin
          state_d   = PLAY2;
          beat_d    = '0;
          score_clr = 1'b1;
        end else if (nav) begin
          state_d = SEL_SONG1;
        end
      end
      PLAY1: begin
        score_inc = note_hit;
        if (btn_center) begin
          state_d = PLAY1_PS;
        end else if (beat_tick) begin
          start_d = 1'b1;
          beat_d  = beat_cnt + BEAT_W'(1);
          if (beat_cnt == LAST1) state_d = ENDING;
        end
      end
      PLAY2: begin
        score_inc = note_hit;
        if (btn_center) begin
          state_d = PLAY2_PS;
        end else if (beat_tick) begin
          start_d = 1'b1;
          beat_d  = beat_cnt + BEAT_W'(1);
          if (beat_cnt == LAST2) state_d = ENDING;
        end
      end
      ENDING: begin
        if (btn_center) state_d = SEL_SONG1;
      end
      PLAY1_PS: begin
        if (btn_center)  state_d = PLAY1;
        else if (nav)    state_d = PLAY1_PM;
      end
      PLAY1_PM: begin
        if (btn_center) begin
          state_d   = SEL_SONG1;
          beat_d    = '0;
          score_clr = 1'b1;
        end else if (nav) begin
          state_d = PLAY1_PS;
        end
      end
      PLAY2_PS: begin
        if (btn_center)  state_d = PLAY2;
        else if (nav)    state_d = PLAY2_PM;
      end
      PLAY2_PM: begin
        if (btn_center) begin
          state_d   = SEL_SONG2;
          beat_d    = '0;
          score_clr = 1'b1;
        end else if (nav) begin
          state_d = PLAY2_PS;
        end
      end
      default: state_d = SEL_SONG1;
    endcase
  end

  // State, beat count and step pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEL_SONG1;
      beat_cnt   <= '0;
      start_sign <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt   <= beat_d;
      start_sign <= start_d;
    end
  end

  assign mode = state_q;

  sat_counter #(.W(SCORE_W)) u_score (
    .clk (clk),
    .rst (rst),
    .clr (score_clr),
    .inc (score_inc),
    .cnt (score)
  );

endmodule

// File: tb/tb_rhythm_ctrl.sv
// Directed bench for rhythm_ctrl with a rule-level reference model checked
// every cycle, plus literal spot checks that pin the model.
module tb_rhythm_ctrl;

  localparam int S1 = 4;
  localparam int S2 = 160;
  localparam int SW = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0;
  logic          beat_tick = 1'b0, note_hit = 1'b0;
  logic [3:0]    mode;
  logic          start_sign;
  logic [9:0]    beat_cnt;
  logic [SW-1:0] score;

  rhythm_ctrl #(.SONG1_LEN(S1), .SONG2_LEN(S2), .SCORE_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_center (btn_center),
    .beat_tick  (beat_tick),
    .note_hit   (note_hit),
    .mode       (mode),
    .start_sign (start_sign),
    .beat_cnt   (beat_cnt),
    .score      (score)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int m_mode  = 0;
  int m_beat  = 0;
  int m_score = 0;
  int m_start = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_beat = 0; m_score = 0; m_start = 0;
  endtask

  // One clock of game rules, applied to the inputs sampled at that edge.
  task automatic model_step(input bit l, input bit r, input bit c, input bit t, input bit h);
    bit nav;
    int len;
    nav = l | r;
    m_start = 0;
    case (m_mode)
      0: if (c) begin m_mode = 2; m_beat = 0; m_score = 0; end
         else if (nav) m_mode = 1;
      1: if (c) begin m_mode = 3; m_beat = 0; m_score = 0; end
         else if (nav) m_mode = 0;
      2, 3: begin
        len = (m_mode == 2) ? S1 : S2;
        if (h && m_score < SMAX) m_score++;
        if (c) m_mode = (m_mode == 2) ? 5 : 7;
        else if (t) begin
          m_start = 1;
          m_beat++;
          if (m_beat == len) m_mode = 4;
        end
      end
      4: if (c) m_mode = 0;
      5, 7: if (c) m_mode = (m_mode == 5) ? 2 : 3;
            else if (nav) m_mode = m_mode + 1;
      6, 8: if (c) begin m_mode = (m_mode == 6) ? 0 : 1; m_beat = 0; m_score = 0; end
            else if (nav) m_mode = m_mode - 1;
      default: m_mode = 0;
    endcase
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then release.
  task automatic cyc(input bit l, input bit r, input bit c, input bit t, input bit h);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_center = c; beat_tick = t; note_hit = h;
    @(posedge clk);
    model_step(l, r, c, t, h);
    #2;
    btn_left = 0; btn_right = 0; btn_center = 0; beat_tick = 0; note_hit = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        chk("mode",       32'(mode),       32'(m_mode));
        chk("start_sign", 32'(start_sign), 32'(m_start));
        chk("beat_cnt",   32'(beat_cnt),   32'(m_beat));
        chk("score",      32'(score),      32'(m_score));
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mode",  32'(mode),       32'd0);
    chk("rst_beat",  32'(beat_cnt),   32'd0);
    chk("rst_score", 32'(score),      32'd0);
    chk("rst_start", 32'(start_sign), 32'd0);
    idle(2);

    // menu navigation into song 2
    cyc(0, 1, 0, 0, 0);
    chk("sel2_mode", 32'(mode), 32'd1);
    cyc(0, 0, 1, 0, 0);
    chk("play2_mode", 32'(mode), 32'd3);
    chk("play2_beat", 32'(beat_cnt), 32'd0);
    chk("play2_score", 32'(score), 32'd0);

    // seven beats with a couple of hits, navigation ignored while playing
    for (int i = 0; i < 7; i++) begin
      cyc(i == 2, i == 2, 0, 1, i == 3 || i == 5);
      idle(1);
    end
    chk("p2_beat7", 32'(beat_cnt), 32'd7);
    chk("p2_score2", 32'(score), 32'd2);

    // pause wins over a coincident tick
    cyc(0, 0, 1, 1, 0);
    chk("pause_mode", 32'(mode), 32'd7);
    chk("pause_beat", 32'(beat_cnt), 32'd7);
    chk("pause_nostart", 32'(start_sign), 32'd0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 0);
    chk("resume_mode", 32'(mode), 32'd3);
    cyc(0, 0, 0, 1, 0);
    chk("resume_beat8", 32'(beat_cnt), 32'd8);
    chk("resume_start", 32'(start_sign), 32'd1);
    idle(1);
    chk("start_oneshot", 32'(start_sign), 32'd0);

    // pause -> menu via both nav buttons, back to song 2 selection
    cyc(0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("pm2_mode", 32'(mode), 32'd8);
    cyc(0, 0, 1, 0, 0);
    chk("menu2_mode", 32'(mode), 32'd1);
    chk("menu2_beat", 32'(beat_cnt), 32'd0);
    chk("menu2_score", 32'(score), 32'd0);

    // song 1: score saturation and frozen score while paused
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1);
    chk("sat_score", 32'(score), 32'd7);
    cyc(0, 0, 1, 0, 0);
    chk("ps1_mode", 32'(mode), 32'd5);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk("ps1_score", 32'(score), 32'd7);
    chk("ps1_beat", 32'(beat_cnt), 32'd0);
    cyc(0, 1, 0, 0, 0);
    chk("pm1_mode", 32'(mode), 32'd6);
    cyc(0, 0, 1, 0, 0);
    chk("menu1_mode", 32'(mode), 32'd0);
    chk("menu1_score", 32'(score), 32'd0);

    // song 1 to the end; final tick carries a hit
    cyc(1, 0, 1, 0, 0);
    chk("center_over_nav", 32'(mode), 32'd2);
    for (int i = 0; i < S1; i++) begin
      cyc(0, 0, 0, 1, i == S1 - 1);
      chk("end_tick_start", 32'(start_sign), 32'd1);
      idle(1);
    end
    chk("end_mode", 32'(mode), 32'd4);
    chk("end_beat", 32'(beat_cnt), 32'd4);
    chk("end_score", 32'(score), 32'd1);
    cyc(0, 0, 0, 1, 1);
    chk("end_no_start", 32'(start_sign), 32'd0);
    cyc(1, 1, 0, 0, 0);
    chk("end_nav_ignored", 32'(mode), 32'd4);
    cyc(0, 0, 1, 0, 0);
    chk("end_exit_mode", 32'(mode), 32'd0);
    chk("end_exit_beat", 32'(beat_cnt), 32'd4);

    // song 2 up to beat 50, then async reset between edges
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 50; i++) cyc(0, 0, 0, 1, i % 10 == 0);
    chk("p2_beat50", 32'(beat_cnt), 32'd50);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_mode",  32'(mode),       32'd0);
    chk("async_beat",  32'(beat_cnt),   32'd0);
    chk("async_score", 32'(score),      32'd0);
    chk("async_start", 32'(start_sign), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    cyc(0, 1, 0, 0, 0);
    chk("post_rst_nav", 32'(mode), 32'd1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rhythm_ctrl.md
RHYTHM_CTRL -- requirements
Module: rhythm_ctrl

Interface
REQ-001 Parameter SONG1_LEN, default 128: number of beats in song 1.
REQ-002 Parameter SONG2_LEN, default 160: number of beats in song 2.
REQ-003 Parameter SCORE_W, default 10: score counter width.
REQ-004 Port clk  in  1: system clock, all state changes on its rising edge.
REQ-005 Port rst  in  1: reset, asynchronous, active-high.
REQ-006 Port btn_left  in  1: debounced one-cycle pulse, navigate left.
REQ-007 Port btn_right  in  1: debounced one-cycle pulse, navigate right.
REQ-008 Port btn_center  in  1: debounced one-cycle pulse, select/pause.
REQ-009 Port beat_tick  in  1: one-cycle pulse per beat from the tempo divider.
REQ-010 Port note_hit  in  1: one-cycle pulse per correct player hit.
REQ-011 Port mode  out  4: current game state code, drives the note spectrum generator.
REQ-012 Port start_sign  out  1: one-cycle pulse that advances the note spectrum by one step.
REQ-013 Port beat_cnt  out  10: beats elapsed in the current song.
REQ-014 Port score  out  SCORE_W: hits in the current song, saturating.

Function
REQ-015 States and codes: SEL_SONG1=0, SEL_SONG2=1, PLAY1=2, PLAY2=3, ENDING=4, PLAY1_PS=5, PLAY1_PM=6, PLAY2_PS=7, PLAY2_PM=8; codes 9-15 unreachable and recover to SEL_SONG1 on the next clock.
REQ-016 PS = paused with "resume" highlighted; PM = paused with "return to menu" highlighted.
REQ-017 Input priority in every state: btn_center over btn_left/btn_right; left and right together count as one navigation event.
REQ-018 SEL_SONG1: left/right -> SEL_SONG2; center -> PLAY1, beat_cnt and score cleared.
REQ-019 SEL_SONG2: left/right -> SEL_SONG1; center -> PLAY2, beat_cnt and score cleared.
REQ-020 PLAYn, beat_tick without center: start_sign=1 on the next cycle, beat_cnt+1.
REQ-021 PLAYn, beat_tick when beat_cnt = SONGn_LEN-1: start_sign pulses, beat_cnt becomes SONGn_LEN, next state ENDING.
REQ-022 PLAYn, center: next state PLAYn_PS.
REQ-023 PLAYn, beat_tick and center in the same cycle: pause wins, tick dropped, no start_sign, beat_cnt unchanged.
REQ-024 PLAYn_PS: left/right -> PLAYn_PM; center -> PLAYn with beat_cnt and score held.
REQ-025 PLAYn_PM: left/right -> PLAYn_PS; center -> SEL_SONGn with beat_cnt and score cleared.
REQ-026 ENDING: beat_cnt and score frozen; center -> SEL_SONG1; left/right ignored.
REQ-027 start_sign is registered and never asserted outside PLAY1/PLAY2; latency from beat_tick is exactly 1 cycle.
REQ-028 Pause states, SEL states and ENDING: beat_tick ignored.
REQ-029 score increments on note_hit only in PLAY1/PLAY2, saturates at 2^SCORE_W-1 and never wraps.
REQ-030 note_hit coincident with the REQ-021 final tick is counted.
REQ-031 mode is registered and equals the state code; no combinational path from inputs to any output.

Reset
REQ-032 rst asserted at any time, including mid-song or while paused: mode=SEL_SONG1, start_sign=0, beat_cnt=0, score=0 immediately, without waiting for clk.
REQ-033 First transition after rst deassertion occurs on the first clk edge with a valid input pulse.

Structure
REQ-034 Shared package rhythm_pkg holds the nine state codes and the beat_cnt width; the spectrum generator imports the same codes.
REQ-035 One sub-module sat_counter (width parameter; inc, clr, saturating) instantiated for score; the FSM and beat counter stay in rhythm_ctrl.

Verification
REQ-036 Reset, right pulse, center pulse -> mode 0,1,3; beat_cnt=0, score=0.
REQ-037 PLAY1 with SONG1_LEN=4: 4 beat_ticks -> 4 start_sign pulses each 1 cycle after a tick, beat_cnt=4, mode=4; a 5th tick produces no pulse.
REQ-038 PLAY2 at beat_cnt=7: center together with beat_tick -> mode=7, beat_cnt=7, no start_sign; center again -> mode=3, next tick gives beat_cnt=8.
REQ-039 PLAY1, pause, right, center -> mode 5,6,0; beat_cnt=0, score=0.
REQ-040 SCORE_W=3: 9 note_hits in PLAY1 -> score=7; 2 note_hits in PLAY1_PS -> score still 7.
REQ-041 rst pulse between clk edges in PLAY2 with beat_cnt=50 -> outputs at reset values before the next clk edge.
